// File: rtl/kmap_mux_equiv_if.sv
// Bus bundle for kmap_mux_equiv: sample request (in_valid/abcd) and the
// registered evaluation results. The master drives samples, the slave is the
// evaluator.
interface kmap_mux_equiv_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 in_valid;
   logic [3:0]           abcd;
   logic                 out_valid;
   logic                 y_mux8;
   logic                 y_mux4;
   logic                 y_sop;
   logic                 mismatch;
   logic                 err_sticky;
   logic [ERR_CNT_W-1:0] err_count;

   modport master (
      output in_valid, abcd,
      input  out_valid, y_mux8, y_mux4, y_sop, mismatch, err_sticky, err_count
   );

   modport slave (
      input  in_valid, abcd,
      output out_valid, y_mux8, y_mux4, y_sop, mismatch, err_sticky, err_count
   );
endinterface

// File: rtl/kmap_mux_equiv.sv
// kmap_mux_equiv: evaluates F(a,b,c,d) = sum m(0,1,2,5,6,8,9,11,13,14,15)
// three independent ways (8:1 mux, two enabled 4:1 muxes ORed, minimal SOP),
// registers the results with one cycle of latency and cross-checks them
// against each other and against the GOLDEN truth table.
// Optional build macro KMAP_SELFTEST_EN adds st_start/st_done and an internal
// 16-cycle sweep of all minterms that overrides the external inputs.
module kmap_mux_equiv #(
   parameter int          ERR_CNT_W = 8,
   parameter logic [15:0] GOLDEN    = 16'hEB67
) (
   input  logic clk,
   input  logic rst_n,
`ifdef KMAP_SELFTEST_EN
   input  logic st_start,
   output logic st_done,
`endif
   kmap_mux_equiv_if.slave bus
);

   logic       eff_valid;
   logic [3:0] eff_abcd;

`ifdef KMAP_SELFTEST_EN
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} st_state_t;

   st_state_t  st_state;
   logic [3:0] st_cnt;
   logic       st_start_q;

   // Self-test sequencer: on a rising st_start sweep minterms 0..15, then
   // pulse st_done once the minterm-15 result has been registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_state   <= ST_IDLE;
         st_cnt     <= 4'd0;
         st_start_q <= 1'b0;
         st_done    <= 1'b0;
      end else begin
         st_start_q <= st_start;
         st_done    <= 1'b0;
         case (st_state)
            ST_IDLE: begin
               if (st_start && !st_start_q) begin
                  st_state <= ST_RUN;
                  st_cnt   <= 4'd0;
               end
            end
            ST_RUN: begin
               st_cnt <= st_cnt + 4'd1;
               if (st_cnt == 4'd15) begin
                  st_state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               st_done  <= 1'b1;
               st_state <= ST_IDLE;
            end
            default: st_state <= ST_IDLE;
         endcase
      end
   end

   assign eff_valid = (st_state == ST_RUN) ? 1'b1   : bus.in_valid;
   assign eff_abcd  = (st_state == ST_RUN) ? st_cnt : bus.abcd;
`else
   assign eff_valid = bus.in_valid;
   assign eff_abcd  = bus.abcd;
`endif

   logic a, b, c, d;
   assign {a, b, c, d} = eff_abcd;

   logic y8_nxt;
   logic mux_a;
   logic mux_b;
   logic y4_nxt;
   logic ysop_nxt;
   logic gold_bit;
   logic mm_nxt;

   // Combinational evaluation of the three paths plus the golden lookup.
   // NOTE: every output gets a default before the case/if so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      y8_nxt = 1'b0;
      case ({b, c, d})
         3'd0: y8_nxt = 1'b1;
         3'd1: y8_nxt = 1'b1;
         3'd2: y8_nxt = ~a;
         3'd3: y8_nxt = a;
         3'd4: y8_nxt = 1'b0;
         3'd5: y8_nxt = 1'b1;
         3'd6: y8_nxt = 1'b1;
         3'd7: y8_nxt = a;
         default: y8_nxt = 1'b0;
      endcase

      // MuxA is enabled (active-low) by b, MuxB by ~b; a disabled mux drives 0.
      mux_a = 1'b0;
      if (!b) begin
         case ({c, d})
            2'd0: mux_a = 1'b1;
            2'd1: mux_a = 1'b1;
            2'd2: mux_a = ~a;
            2'd3: mux_a = a;
            default: mux_a = 1'b0;
         endcase
      end

      mux_b = 1'b0;
      if (b) begin
         case ({c, d})
            2'd0: mux_b = 1'b0;
            2'd1: mux_b = 1'b1;
            2'd2: mux_b = 1'b1;
            2'd3: mux_b = a;
            default: mux_b = 1'b0;
         endcase
      end

      y4_nxt   = mux_a | mux_b;
      ysop_nxt = (~b & ~c) | (~c & d) | (b & c & ~d) | (a & c & d) | (~a & ~b & ~d);
      gold_bit = GOLDEN[eff_abcd];
      mm_nxt   = !((y8_nxt == y4_nxt) && (y4_nxt == ysop_nxt) && (ysop_nxt == gold_bit));
   end

   // Result register and error bookkeeping; results hold when no sample.
   // NOTE: state is updated with non-blocking assignments so every register
   // sees pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid  <= 1'b0;
         bus.y_mux8     <= 1'b0;
         bus.y_mux4     <= 1'b0;
         bus.y_sop      <= 1'b0;
         bus.mismatch   <= 1'b0;
         bus.err_sticky <= 1'b0;
         bus.err_count  <= '0;
      end else if (eff_valid) begin
         bus.out_valid <= 1'b1;
         bus.y_mux8    <= y8_nxt;
         bus.y_mux4    <= y4_nxt;
         bus.y_sop     <= ysop_nxt;
         bus.mismatch  <= mm_nxt;
         // Error state is updated in the same edge that presents the
         // mismatching result, so it lines up with out_valid=1.
         if (mm_nxt) begin
            bus.err_sticky <= 1'b1;
            if (bus.err_count != '1) begin
               bus.err_count <= bus.err_count + ERR_CNT_W'(1);
            end
         end
      end else begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kmap_mux_equiv.sv
// Self-checking bench for kmap_mux_equiv. Two instances: one with the true
// truth table, one with a corrupted GOLDEN (minterm 0 cleared) to exercise
// the mismatch/sticky/saturating counter. Expected values come from a model
// built on the minterm list.
module tb_kmap_mux_equiv;
   localparam int          W      = 8;
   localparam logic [15:0] GOLD0  = 16'hEB67;
   localparam logic [15:0] GOLD1  = 16'hEB66;

   logic clk;
   logic rst_n;

   kmap_mux_equiv_if #(.ERR_CNT_W(W)) bus0 ();
   kmap_mux_equiv_if #(.ERR_CNT_W(W)) bus1 ();

`ifdef KMAP_SELFTEST_EN
   logic st_start0, st_done0, st_start1, st_done1;
`endif

   kmap_mux_equiv #(.ERR_CNT_W(W), .GOLDEN(GOLD0)) dut0 (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef KMAP_SELFTEST_EN
      .st_start (st_start0),
      .st_done  (st_done0),
`endif
      .bus      (bus0)
   );

   kmap_mux_equiv #(.ERR_CNT_W(W), .GOLDEN(GOLD1)) dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef KMAP_SELFTEST_EN
      .st_start (st_start1),
      .st_done  (st_done1),
`endif
      .bus      (bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic         v;
      logic         y8;
      logic         y4;
      logic         ys;
      logic         mm;
      logic         st;
      logic [W-1:0] cnt;
   } exp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t e0;
   exp_t e1;

   // F straight from the minterm list.
   function automatic logic f_ref(input logic [3:0] x);
      int mt [11] = '{0, 1, 2, 5, 6, 8, 9, 11, 13, 14, 15};
      foreach (mt[i]) begin
         if (mt[i] == int'(x)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic exp_t model_next(input exp_t e, input logic v, input logic [3:0] x,
                                       input logic [15:0] gold);
      exp_t n;
      logic f;
      n   = e;
      n.v = v;
      if (v) begin
         f    = f_ref(x);
         n.y8 = f;
         n.y4 = f;
         n.ys = f;
         n.mm = (f != gold[x]);
         if (n.mm) begin
            n.st = 1'b1;
            if (n.cnt != {W{1'b1}}) n.cnt = n.cnt + 1'b1;
         end
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_both(input string ph);
      check({ph, ".d0.out_valid"},  32'(bus0.out_valid),  32'(e0.v));
      check({ph, ".d0.y_mux8"},     32'(bus0.y_mux8),     32'(e0.y8));
      check({ph, ".d0.y_mux4"},     32'(bus0.y_mux4),     32'(e0.y4));
      check({ph, ".d0.y_sop"},      32'(bus0.y_sop),      32'(e0.ys));
      check({ph, ".d0.mismatch"},   32'(bus0.mismatch),   32'(e0.mm));
      check({ph, ".d0.err_sticky"}, 32'(bus0.err_sticky), 32'(e0.st));
      check({ph, ".d0.err_count"},  32'(bus0.err_count),  32'(e0.cnt));
      check({ph, ".d1.out_valid"},  32'(bus1.out_valid),  32'(e1.v));
      check({ph, ".d1.y_mux8"},     32'(bus1.y_mux8),     32'(e1.y8));
      check({ph, ".d1.mismatch"},   32'(bus1.mismatch),   32'(e1.mm));
      check({ph, ".d1.err_sticky"}, 32'(bus1.err_sticky), 32'(e1.st));
      check({ph, ".d1.err_count"},  32'(bus1.err_count),  32'(e1.cnt));
   endtask

   // Apply one sample to each instance, clock it in, update model, compare.
   task automatic step(input string ph, input logic v0, input logic [3:0] x0,
                       input logic v1, input logic [3:0] x1);
      bus0.in_valid = v0;
      bus0.abcd     = x0;
      bus1.in_valid = v1;
      bus1.abcd     = x1;
      @(posedge clk);
      #1;
      e0 = model_next(e0, v0, x0, GOLD0);
      e1 = model_next(e1, v1, x1, GOLD1);
      check_both(ph);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      e0 = '0;
      e1 = '0;
      check_both("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus0.in_valid = 1'b1;
      bus0.abcd     = 4'b0000;
      bus1.in_valid = 1'b1;
      bus1.abcd     = 4'b0000;
`ifdef KMAP_SELFTEST_EN
      st_start0 = 1'b0;
      st_start1 = 1'b0;
`endif
      e0 = '0;
      e1 = '0;

      // Reset held across several edges with in_valid=1: everything stays 0.
      repeat (3) @(posedge clk);
      #1;
      check_both("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // First sample after release.
      step("first", 1'b1, 4'b0000, 1'b0, 4'b0000);

      // Exhaustive sweep, with an independent check against the expected
      // output sequence 1,1,1,0,0,1,1,0,1,1,0,1,0,1,1,1.
      begin
         logic [15:0] seq;
         seq = 16'b1110_1011_0110_0111;
         for (int i = 0; i < 16; i++) begin
            step("sweep", 1'b1, 4'(i), 1'b0, 4'b0000);
            check("sweep.seq", 32'(bus0.y_mux8), 32'(seq[i]));
         end
      end

      // Gap handling: 1011 then three idle cycles; results hold at 1.
      step("gap_in", 1'b1, 4'b1011, 1'b0, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         step("gap_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);
      end

      // Mid-stream async reset between edges: outputs clear before next edge.
      for (int i = 0; i < 8; i++) begin
         step("pre_arst", 1'b1, 4'(i + 5), 1'b1, 4'(i));
      end
      #2;
      rst_n = 1'b0;
      #1;
      e0 = '0;
      e1 = '0;
      check_both("async_rst");
      #1;
      rst_n = 1'b1;
      step("post_arst", 1'b1, 4'b1110, 1'b0, 4'b0000);

      // Randomized traffic on both instances.
      for (int i = 0; i < 200; i++) begin
         logic       v0, v1;
         logic [3:0] x0, x1;
         v0 = ($urandom_range(0, 3) != 0);
         v1 = ($urandom_range(0, 3) != 0);
         x0 = 4'($urandom_range(0, 15));
         x1 = 4'($urandom_range(0, 15));
         step("rand", v0, x0, v1, x1);
      end

      // Corrupted-golden instance: from reset, minterm 0 flags a mismatch,
      // then repeated hits saturate the counter at all-ones.
      @(negedge clk);
      do_reset();
      step("gold_first", 1'b0, 4'b0000, 1'b1, 4'b0000);
      check("gold_first.mm",  32'(bus1.mismatch),   32'd1);
      check("gold_first.cnt", 32'(bus1.err_count),  32'd1);
      for (int i = 0; i < 299; i++) begin
         step("gold_sat", 1'b0, 4'b0000, 1'b1, 4'b0000);
      end
      check("gold_sat.final", 32'(bus1.err_count), 32'd255);
      step("gold_clean", 1'b0, 4'b0000, 1'b1, 4'b0101);

`ifdef KMAP_SELFTEST_EN
      // Self-test: the start is captured on the first edge, 16 sweep edges
      // follow, and st_done is registered on the edge after that.
      @(negedge clk);
      do_reset();
      bus0.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
      @(posedge clk);
      #1;
      st_start0 = 1'b1;
      begin
         int  edges;
         bit  seen;
         edges = 0;
         seen  = 1'b0;
         while (!seen && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (st_done0) seen = 1'b1;
         end
         check("st.done_seen", 32'(seen), 32'd1);
         check("st.latency", 32'(edges), 32'd18);
         check("st.sticky", 32'(bus0.err_sticky), 32'd0);
         @(posedge clk);
         #1;
         check("st.done_pulse", 32'(st_done0), 32'd0);
      end
      st_start0 = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
